// File: rtl/next_pc_unit_pkg.sv
// Shared types for the fetch front end: PC sequencer states, reset vector and branch op codes.
package next_pc_unit_pkg;

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StStall,
    StHalted,
    StTrap
  } pcState_e;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

  // Branch unit operation codes; the branch unit raises NextPCSrc from these.
  typedef enum logic [2:0] {
    BrBeq  = 3'd0,
    BrBne  = 3'd1,
    BrBlt  = 3'd2,
    BrBge  = 3'd3,
    BrBltu = 3'd4,
    BrBgeu = 3'd5,
    BrJal  = 3'd6,
    BrJalr = 3'd7
  } brOp_e;

endpackage

// File: rtl/next_pc_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] countQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countQ <= '0;
    end else if (inc && (countQ != '1)) begin
      countQ <= countQ + One;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/next_pc_unit.sv
// PC sequencer: sequential/redirect fetch addressing with stall, halt and misaligned-target trap.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DefaultResetVector,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             NextPCSrc,
  input  logic [31:0]      BrTarget,
  input  logic             halt,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             retired,
  output logic             trap,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] taken_count
);

  pcState_e    stateQ;
  logic [31:0] pcQ;
  logic [31:0] trapPcQ;

  logic active;
  logic accept;
  logic misaligned;
  logic takeRedirect;

  assign active     = (stateQ == StRun) || (stateQ == StStall);
  assign accept     = active && imem_ready;
  // halt wins over a redirect, so a misaligned target is only fatal without halt.
  assign misaligned = NextPCSrc && BrTarget[1] && !halt;
  assign takeRedirect = accept && NextPCSrc && !halt && !BrTarget[1];

  assign imem_req = active;
  assign retired  = accept && !misaligned;
  assign PC       = pcQ;
  assign PCPlus4  = pcQ + 32'd4;
  assign trap     = (stateQ == StTrap);
  assign trap_pc  = trapPcQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= StBoot;
      pcQ     <= RESET_VECTOR;
      trapPcQ <= '0;
    end else begin
      unique case (stateQ)
        StBoot: stateQ <= StRun;
        StRun, StStall: begin
          if (!imem_ready) begin
            stateQ <= StStall;
          end else if (halt) begin
            stateQ <= StHalted;
          end else if (misaligned) begin
            stateQ  <= StTrap;
            trapPcQ <= BrTarget;
          end else begin
            stateQ <= StRun;
            pcQ    <= NextPCSrc ? {BrTarget[31:1], 1'b0} : PCPlus4;
          end
        end
        default: ;  // HALTED and TRAP are left only through reset
      endcase
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_taken_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (takeRedirect),
    .count(taken_count)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: default instance plus a wrap/saturation instance.
module tb_next_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, srcA, haltA, readyA;
  logic [31:0] tgtA;
  logic        reqA, retA, trapA;
  logic [31:0] pcA, pc4A, trapPcA;
  logic [15:0] cntA;

  logic        rstB, srcB, haltB, readyB;
  logic [31:0] tgtB;
  logic        reqB, retB, trapB;
  logic [31:0] pcB, pc4B, trapPcB;
  logic [1:0]  cntB;

  int nRun  = 0;
  int nFail = 0;
  int pulses;

  next_pc_unit u_dutA (
    .clk        (clk),
    .rst_n      (rstA),
    .NextPCSrc  (srcA),
    .BrTarget   (tgtA),
    .halt       (haltA),
    .imem_ready (readyA),
    .imem_req   (reqA),
    .PC         (pcA),
    .PCPlus4    (pc4A),
    .retired    (retA),
    .trap       (trapA),
    .trap_pc    (trapPcA),
    .taken_count(cntA)
  );

  next_pc_unit #(
    .RESET_VECTOR(32'hFFFF_FFF8),
    .CNT_W       (2)
  ) u_dutB (
    .clk        (clk),
    .rst_n      (rstB),
    .NextPCSrc  (srcB),
    .BrTarget   (tgtB),
    .halt       (haltB),
    .imem_ready (readyB),
    .imem_req   (reqB),
    .PC         (pcB),
    .PCPlus4    (pc4B),
    .retired    (retB),
    .trap       (trapB),
    .trap_pc    (trapPcB),
    .taken_count(cntB)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nRun++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstA = 1'b0; srcA = 1'b0; haltA = 1'b0; readyA = 1'b1; tgtA = '0;
    rstB = 1'b0; srcB = 1'b0; haltB = 1'b0; readyB = 1'b1; tgtB = '0;
    tick();
    tick();
    checkEq("rst pc", pcA, 32'h0);
    checkEq("rst req", 32'(reqA), 32'h0);
    checkEq("rst retired", 32'(retA), 32'h0);
    checkEq("rst trap", 32'(trapA), 32'h0);
    checkEq("rst trap_pc", trapPcA, 32'h0);
    checkEq("rst cnt", 32'(cntA), 32'h0);

    // Sequential fetch from reset
    rstA = 1'b1;
    #1;
    checkEq("boot pc", pcA, 32'h0);
    checkEq("boot req", 32'(reqA), 32'h0);
    checkEq("boot retired", 32'(retA), 32'h0);
    tick();
    checkEq("run req", 32'(reqA), 32'h1);
    checkEq("run pc first", pcA, 32'h0);
    pulses = 0;
    for (int i = 1; i <= 3; i++) begin
      if (retA) pulses++;
      tick();
      checkEq("seq pc", pcA, 32'(4 * i));
    end
    checkEq("retired pulses", 32'(pulses), 32'd3);
    checkEq("pcplus4", pc4A, 32'h10);
    tick();
    checkEq("pc 0x10", pcA, 32'h10);

    // Redirect, then misaligned redirect
    srcA = 1'b1; tgtA = 32'h41;
    #1;
    checkEq("br retired", 32'(retA), 32'h1);
    tick();
    checkEq("br pc", pcA, 32'h40);
    checkEq("br cnt", 32'(cntA), 32'h1);
    tgtA = 32'h42;
    #1;
    checkEq("mis retired", 32'(retA), 32'h0);
    tick();
    checkEq("trap", 32'(trapA), 32'h1);
    checkEq("trap_pc", trapPcA, 32'h42);
    checkEq("trap pc held", pcA, 32'h40);
    checkEq("trap req", 32'(reqA), 32'h0);
    checkEq("trap cnt", 32'(cntA), 32'h1);
    srcA = 1'b0;
    tick();
    checkEq("trap sticky", 32'(trapA), 32'h1);
    checkEq("trap frozen pc", pcA, 32'h40);
    checkEq("trap retired", 32'(retA), 32'h0);

    // Asynchronous reset out of TRAP
    rstA = 1'b0;
    #1;
    checkEq("areset trap", 32'(trapA), 32'h0);
    checkEq("areset trap_pc", trapPcA, 32'h0);
    checkEq("areset pc", pcA, 32'h0);
    checkEq("areset cnt", 32'(cntA), 32'h0);
    checkEq("areset req", 32'(reqA), 32'h0);
    tick();
    rstA = 1'b1;
    #1;
    checkEq("reboot req", 32'(reqA), 32'h0);
    tick();
    checkEq("rerun req", 32'(reqA), 32'h1);

    // Stall at 0x8 with a pending redirect; halt during stall is ignored
    tick();
    tick();
    checkEq("stall setup pc", pcA, 32'h8);
    readyA = 1'b0; srcA = 1'b1; tgtA = 32'h80; haltA = 1'b1;
    #1;
    checkEq("stall retired", 32'(retA), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkEq("stall pc", pcA, 32'h8);
      checkEq("stall retired hold", 32'(retA), 32'h0);
      checkEq("stall req", 32'(reqA), 32'h1);
      checkEq("stall cnt", 32'(cntA), 32'h0);
    end
    haltA = 1'b0; readyA = 1'b1;
    #1;
    checkEq("unstall retired", 32'(retA), 32'h1);
    tick();
    checkEq("unstall pc", pcA, 32'h80);
    checkEq("unstall cnt", 32'(cntA), 32'h1);

    // Halt overrides a (misaligned) redirect
    tgtA = 32'h20;
    tick();
    checkEq("to 0x20", pcA, 32'h20);
    checkEq("cnt 2", 32'(cntA), 32'h2);
    haltA = 1'b1; tgtA = 32'h42;
    #1;
    checkEq("halt retired", 32'(retA), 32'h1);
    tick();
    checkEq("halt pc", pcA, 32'h20);
    checkEq("halt req", 32'(reqA), 32'h0);
    checkEq("halt no trap", 32'(trapA), 32'h0);
    checkEq("halt cnt", 32'(cntA), 32'h2);
    checkEq("halted retired", 32'(retA), 32'h0);
    tick();
    checkEq("halted pc", pcA, 32'h20);
    rstA = 1'b0;
    #1;
    checkEq("halt reset pc", pcA, 32'h0);
    checkEq("halt reset cnt", 32'(cntA), 32'h0);

    // Wrapping PC and 2-bit saturating counter
    rstB = 1'b1;
    #1;
    checkEq("B boot pc", pcB, 32'hFFFF_FFF8);
    checkEq("B boot req", 32'(reqB), 32'h0);
    tick();
    checkEq("B run pc", pcB, 32'hFFFF_FFF8);
    tick();
    checkEq("B pc fc", pcB, 32'hFFFF_FFFC);
    checkEq("B pcplus4 wrap", pc4B, 32'h0);
    tick();
    checkEq("B pc wrap", pcB, 32'h0);
    srcB = 1'b1; tgtB = 32'h100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkEq("B sat cnt", 32'(cntB), 32'((i < 3) ? i : 3));
    end
    checkEq("B redirect pc", pcB, 32'h100);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
